usb3_descrambler: RTL and testbench

USB3_DESCRAMBLER -- requirements
Module: usb3_descrambler

---
 rtl/usb3_descrambler.sv | 120 ++++++++++++
 tb/tb_usb3_descrambler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/usb3_descrambler.sv
// USB3 receive-side descrambler. It uses a 16-bit Galois LFSR (x^16+x^5+x^4+x^3+1) and handles
// four bytes per clock. A COM byte reseeds the LFSR, a SKP byte is transparent, and the output is registered.
module usb3_descrambler #(
  parameter logic [15:0] LFSR_INIT = 16'hFFFF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] data_in,
  input  logic [3:0]  datak_in,
  input  logic        data_valid,
  input  logic        descram_en,
  input  logic        descram_rst,
  output logic [31:0] data_out,
  output logic [3:0]  datak_out,
  output logic        data_valid_out,
  output logic        locked,
  output logic        com_det
);

  localparam logic [7:0]  COM_SYM   = 8'hBC;
  localparam logic [7:0]  SKP_SYM   = 8'h3C;
  localparam logic [15:0] LFSR_TAPS = 16'h0039;

  // Handshake: data_in/datak_in are consumed on any clock edge with data_valid=1,
  // unless descram_rst or reset_n=0 discards them. Each consumed word appears on
  // data_out exactly one cycle later, qualified by data_valid_out. There is no backpressure.

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [15:0] lfsr;
  logic [15:0] lfsr_word;
  logic [15:0] q;
  logic [31:0] word_descr;
  logic        word_has_com;
  logic [7:0]  byte_v;
  logic [7:0]  ks;
  logic        is_k;

  // Bytes are walked in wire order. Each byte sees the LFSR state left by the byte before it.
  always_comb begin
    q            = lfsr;
    word_descr   = '0;
    word_has_com = 1'b0;
    byte_v       = '0;
    ks           = '0;
    is_k         = 1'b0;
    for (int b = 0; b < 4; b++) begin
      byte_v = data_in[8*b +: 8];
      is_k   = datak_in[b];
      ks     = '0;
      if (is_k && (byte_v == COM_SYM)) begin
        word_descr[8*b +: 8] = byte_v;
        q                    = LFSR_INIT;
        word_has_com         = 1'b1;
      end else if (is_k && (byte_v == SKP_SYM)) begin
        word_descr[8*b +: 8] = byte_v;
      end else begin
        for (int i = 0; i < 8; i++) begin
          ks[i] = q[15];
          q     = {q[14:0], 1'b0} ^ (q[15] ? LFSR_TAPS : 16'h0000);
        end
        word_descr[8*b +: 8] = is_k ? byte_v : (byte_v ^ ks);
      end
    end
    lfsr_word = q;
  end

  always_comb begin
    state_next = state;
    if (descram_rst || !descram_en) begin
      state_next = UNLOCKED;
    end else if (data_valid && word_has_com) begin
      state_next = LOCKED;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= UNLOCKED;
    end else begin
      state <= state_next;
    end
  end

  assign locked = (state == LOCKED);

  // In bypass, the LFSR is frozen so that descrambling resumes where it stopped.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      lfsr           <= LFSR_INIT;
      data_out       <= '0;
      datak_out      <= '0;
      data_valid_out <= 1'b0;
      com_det        <= 1'b0;
    end else begin
      data_valid_out <= 1'b0;
      com_det        <= 1'b0;
      if (descram_rst) begin
        lfsr <= LFSR_INIT;
      end else if (data_valid) begin
        data_valid_out <= 1'b1;
        datak_out      <= datak_in;
        com_det        <= word_has_com;
        if (descram_en) begin
          data_out <= word_descr;
          lfsr     <= lfsr_word;
        end else begin
          data_out <= data_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_usb3_descrambler.sv
// Self-checking bench for usb3_descrambler. It uses directed vectors with known keystream values,
// then random scrambled traffic with COM/SKP/K bytes and data_valid gaps.
module tb_usb3_descrambler;

  localparam logic [15:0] INIT = 16'hFFFF;

  logic        clock;
  logic        reset_n;
  logic [31:0] data_in;
  logic [3:0]  datak_in;
  logic        data_valid;
  logic        descram_en;
  logic        descram_rst;
  logic [31:0] data_out;
  logic [3:0]  datak_out;
  logic        data_valid_out;
  logic        locked;
  logic        com_det;

  usb3_descrambler #(.LFSR_INIT(INIT)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .data_in        (data_in),
    .datak_in       (datak_in),
    .data_valid     (data_valid),
    .descram_en     (descram_en),
    .descram_rst    (descram_rst),
    .data_out       (data_out),
    .datak_out      (datak_out),
    .data_valid_out (data_valid_out),
    .locked         (locked),
    .com_det        (com_det)
  );

  // Clock and reset defaults.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  // Each expected entry is packed as {valid_out, com_det, locked, datak_out, data_out}.
  logic [38:0] exp_q[$];

  // State of the reference model for the descrambler and the independent scrambler.
  logic [15:0] m_lfsr = INIT;
  logic        m_lock = 1'b0;
  logic [31:0] m_dout = '0;
  logic [3:0]  m_kout = '0;
  logic        m_vout = 1'b0;
  logic        m_com  = 1'b0;
  logic [15:0] s_lfsr = INIT;

  // Returns {state after 8 steps, keystream byte}.
  function automatic logic [23:0] ks_gen(input logic [15:0] s);
    logic [7:0] k;
    k = '0;
    for (int i = 0; i < 8; i++) begin
      k[i] = s[15];
      s = (s << 1) ^ (s[15] ? 16'h0039 : 16'h0000);
    end
    return {s, k};
  endfunction

  // Applies the symbol rules to a word. XOR is self-inverse, so the same task both
  // scrambles and descrambles.
  task automatic code_word(input logic [31:0] din, input logic [3:0] kin,
                           inout logic [15:0] st, output logic [31:0] dout);
    logic [7:0]  b;
    logic [23:0] g;
    dout = '0;
    for (int n = 0; n < 4; n++) begin
      b = din[8*n +: 8];
      if (kin[n] && b == 8'hBC) begin
        dout[8*n +: 8] = b;
        st = INIT;
      end else if (kin[n] && b == 8'h3C) begin
        dout[8*n +: 8] = b;
      end else begin
        g = ks_gen(st);
        st = g[23:8];
        dout[8*n +: 8] = kin[n] ? b : (b ^ g[7:0]);
      end
    end
  endtask

  task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver: applies one cycle of inputs and records the model's prediction for that edge.
  task automatic drive(input logic rn, input logic drst, input logic en, input logic vld,
                       input logic [31:0] din, input logic [3:0] kin);
    logic [31:0] w;
    logic        hc;
    reset_n = rn; descram_rst = drst; descram_en = en; data_valid = vld;
    data_in = din; datak_in = kin;
    hc = 1'b0;
    for (int n = 0; n < 4; n++)
      if (kin[n] && din[8*n +: 8] == 8'hBC) hc = 1'b1;
    if (!rn) begin
      m_lfsr = INIT; m_lock = 1'b0; m_dout = '0; m_kout = '0; m_vout = 1'b0; m_com = 1'b0;
    end else if (drst) begin
      m_lfsr = INIT; m_lock = 1'b0; m_vout = 1'b0; m_com = 1'b0;
    end else begin
      if (!en) m_lock = 1'b0;
      m_vout = vld;
      m_com  = vld & hc;
      if (vld) begin
        m_kout = kin;
        if (en) begin
          code_word(din, kin, m_lfsr, w);
          m_dout = w;
          if (hc) m_lock = 1'b1;
        end else begin
          m_dout = din;
        end
      end
    end
    exp_q.push_back({m_vout, m_com, m_lock, m_kout, m_dout});
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: this block checks every clock edge against the model's prediction.
  initial begin
    logic [38:0] e;
    logic [38:0] a;
    forever begin
      @(posedge clock);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {data_valid_out, com_det, locked, datak_out, data_out};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL cycle_check @%0t: got v=%b com=%b lock=%b k=%h d=%h expected v=%b com=%b lock=%b k=%h d=%h",
                   $time, a[38], a[37], a[36], a[35:32], a[31:0],
                   e[38], e[37], e[36], e[35:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w;
    logic [31:0] payload;
    logic [3:0]  kp;
    logic [15:0] saved;
    int          r;

    reset_n = 1'b0; descram_rst = 1'b0; descram_en = 1'b1; data_valid = 1'b0;
    data_in = '0; datak_in = '0;

    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 4'hF);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0);

    // These are the known keystream words that follow reset.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h14C017FF, 4'b0000);
    check_lit("first_word", m_dout, 32'h00000000);
    check_lit("first_unlocked", {31'b0, m_lock}, 32'h0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'hC017FFBC, 4'b0001);
    check_lit("com_word", m_dout, 32'h000000BC);
    check_lit("com_det_lock", {30'b0, m_com, m_lock}, 32'h3);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h17FF3CBC, 4'b0011);
    check_lit("skp_word", m_dout, 32'h00003CBC);

    // Zero-payload words separated by a data_valid gap.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0);
    s_lfsr = INIT;
    code_word(32'h0, 4'h0, s_lfsr, w);
    check_lit("scrambler_seed_word", w, 32'h14C017FF);
    drive(1'b1, 1'b0, 1'b1, 1'b1, w, 4'h0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, $urandom, 4'h0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, $urandom, 4'hF);
    code_word(32'h0, 4'h0, s_lfsr, w);
    drive(1'b1, 1'b0, 1'b1, 1'b1, w, 4'h0);
    check_lit("gap_continuity", m_dout, 32'h0);

    // A mid-stream descram_rst is followed by a bypass that must freeze the LFSR.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'hC017FFBC, 4'b0001);
    drive(1'b1, 1'b1, 1'b1, 1'b1, $urandom, 4'h0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h14C017FF, 4'b0000);
    check_lit("after_descram_rst", m_dout, 32'h0);
    check_lit("after_descram_rst_lock", {31'b0, m_lock}, 32'h0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h000000BC, 4'b0001);
    saved = m_lfsr;
    for (int i = 0; i < 3; i++) begin
      w = $urandom;
      drive(1'b1, 1'b0, 1'b0, 1'b1, w, 4'h0);
      check_lit("bypass_data", m_dout, w);
    end
    check_lit("bypass_lfsr_hold", {16'h0, m_lfsr}, {16'h0, saved});
    check_lit("bypass_unlocked", {31'b0, m_lock}, 32'h0);
    s_lfsr = INIT;
    code_word(32'h000000BC, 4'b0001, s_lfsr, w);
    code_word(32'h0, 4'h0, s_lfsr, w);
    drive(1'b1, 1'b0, 1'b1, 1'b1, w, 4'h0);
    check_lit("resume_after_bypass", m_dout, 32'h0);

    // A reset asserted mid-stream discards the word in flight.
    drive(1'b0, 1'b0, 1'b1, 1'b1, $urandom, 4'h0);

    // Random scrambled traffic. The model output must reproduce each payload.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0);
    s_lfsr = INIT;
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        drive(1'b1, 1'b0, 1'b1, 1'b0, $urandom, 4'($urandom));
      end
      payload = $urandom;
      kp = '0;
      for (int b = 0; b < 4; b++) begin
        r = $urandom_range(0, 99);
        if (r < 6) begin
          payload[8*b +: 8] = 8'hBC; kp[b] = 1'b1;
        end else if (r < 12) begin
          payload[8*b +: 8] = 8'h3C; kp[b] = 1'b1;
        end else if (r < 15) begin
          payload[8*b +: 8] = (r[0]) ? 8'hF7 : 8'hFE; kp[b] = 1'b1;
        end
      end
      code_word(payload, kp, s_lfsr, w);
      drive(1'b1, 1'b0, 1'b1, 1'b1, w, kp);
      check_lit("random_payload", m_dout, payload);
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0);

    #5;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
